// File: rtl/cordic_sqrt_pkg.sv
// Shared types and defaults for the cordic_sqrt operand path (prenorm, tag pipe, denorm).
package cordic_sqrt_pkg;

  localparam int DSIZE_DEF    = 16;
  localparam int SQRT_LAT_DEF = 6;

  // Width of the shift-pair count k, which ranges over 0..dsize/2-1.
  function automatic int exp_width(input int dsize);
    return $clog2(dsize / 2 + 1);
  endfunction

  localparam int EXPW_DEF = exp_width(DSIZE_DEF);

  typedef enum logic [1:0] {IDLE, SHIFT, ISSUE} state_e;

  typedef struct packed {
    logic                valid;
    logic [EXPW_DEF-1:0] exp;
    logic                zero;
  } tag_t;

endpackage

// File: rtl/cordic_tag_pipe.sv
// Reset-cleared fixed-depth delay line for {valid, exp, zero} tags; no stall path.
module cordic_tag_pipe #(
  parameter int DEPTH = 6,
  parameter int W     = 6
) (
  input  logic         clock,
  input  logic         rst_n,
  input  logic [W-1:0] din_i,
  output logic [W-1:0] dout_o
);

  logic [DEPTH-1:0][W-1:0] stage_q;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      stage_q <= '0;
    end else begin
      stage_q[0] <= din_i;
      for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign dout_o = stage_q[DEPTH-1];

endmodule

// File: rtl/cordic_sqrt_prenorm.sv
// Normalizes an unsigned fraction into [1/4,1) by even left shifts ahead of cordic_sqrt.
// Build option SQRT_PRENORM_FAST_EN: single-cycle leading-zero-pair encoder instead of SHIFT loop.
module cordic_sqrt_prenorm
  import cordic_sqrt_pkg::*;
#(
  parameter int  DSIZE    = DSIZE_DEF,
  parameter int  SQRT_LAT = SQRT_LAT_DEF,
  localparam int EXPW     = exp_width(DSIZE)
) (
  input  logic             clock,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DSIZE-1:0] in_data,
  output logic [DSIZE-1:0] d,
  output logic             issue,
  output logic             q_valid,
  output logic [EXPW-1:0]  q_exp,
  output logic             q_zero
);

  localparam int TAGW = EXPW + 2;

  state_e           state_q, state_d;
  logic [DSIZE-1:0] sh_q, sh_d, d_q, d_d, sh_next;
  logic [EXPW-1:0]  k_q, k_d, tag_k_q, tag_k_d;
  logic             zero_q, zero_d;
  logic             tag_vld_q, tag_vld_d, tag_zero_q, tag_zero_d;

`ifdef SQRT_PRENORM_FAST_EN
  logic [EXPW-1:0] lz_k;

  // Highest nonzero bit pair wins; a zero operand leaves k at 0.
  always_comb begin
    lz_k = '0;
    for (int i = 0; i < DSIZE/2; i++)
      if (in_data[2*i +: 2] != 2'b00) lz_k = EXPW'(DSIZE/2 - 1 - i);
  end
`endif

  assign sh_next = sh_q << 2;

  always_comb begin
    state_d    = state_q;
    sh_d       = sh_q;
    k_d        = k_q;
    zero_d     = zero_q;
    d_d        = d_q;
    tag_vld_d  = 1'b0;
    tag_k_d    = '0;
    tag_zero_d = 1'b0;
    in_ready   = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          zero_d = (in_data == '0);
`ifdef SQRT_PRENORM_FAST_EN
          sh_d    = in_data << {lz_k, 1'b0};
          k_d     = lz_k;
          state_d = ISSUE;
`else
          sh_d    = in_data;
          k_d     = '0;
          state_d = (in_data == '0 || in_data[DSIZE-1 -: 2] != 2'b00) ? ISSUE : SHIFT;
`endif
        end
      end
      SHIFT: begin
        sh_d = sh_next;
        k_d  = k_q + EXPW'(1);
        if (sh_next[DSIZE-1 -: 2] != 2'b00) state_d = ISSUE;
      end
      ISSUE: begin
        d_d        = zero_q ? '0 : sh_q;
        tag_vld_d  = 1'b1;
        tag_k_d    = k_q;
        tag_zero_d = zero_q;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      sh_q       <= '0;
      k_q        <= '0;
      zero_q     <= 1'b0;
      d_q        <= '0;
      tag_vld_q  <= 1'b0;
      tag_k_q    <= '0;
      tag_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      sh_q       <= sh_d;
      k_q        <= k_d;
      zero_q     <= zero_d;
      d_q        <= d_d;
      tag_vld_q  <= tag_vld_d;
      tag_k_q    <= tag_k_d;
      tag_zero_q <= tag_zero_d;
    end
  end

  assign d     = d_q;
  assign issue = tag_vld_q;

  // Tag registered with d enters the line, so the tail lines up SQRT_LAT edges after d.
  cordic_tag_pipe #(
    .DEPTH (SQRT_LAT),
    .W     (TAGW)
  ) u_tag_pipe (
    .clock  (clock),
    .rst_n  (rst_n),
    .din_i  ({tag_vld_q, tag_k_q, tag_zero_q}),
    .dout_o ({q_valid, q_exp, q_zero})
  );

endmodule
